uart_rx_core: RTL and testbench

//   UART receiver, 8N1 by default: recovers serial frames (start, DATA_BITS LSB-first, one stop) from rxd.

---
 rtl/uart_rx_core_if.sv | 26 ++
 rtl/uart_rx_core.sv | 150 +++++++++++++++
 tb/tb_uart_rx_core.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// Handshake/bus bundle for uart_rx_core: serial input, tick enable, byte output and status.
interface uart_rx_core_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic                 sel;
   logic                 baud_tick;
   logic                 rxd;
   logic                 rd_ack;
   logic [DATA_BITS-1:0] dout;
   logic                 dout_vld;
   logic                 frame_err;
   logic                 overrun;
   logic                 busy;

   // Producer of line/control inputs and consumer of received bytes
   modport master (
      output sel, baud_tick, rxd, rd_ack,
      input  dout, dout_vld, frame_err, overrun, busy
   );

   // Receiver side
   modport slave (
      input  sel, baud_tick, rxd, rd_ack,
      output dout, dout_vld, frame_err, overrun, busy
   );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled mid-bit sampling of start, LSB-first data and one stop bit,
// byte handoff via valid/ack with sticky framing and overrun flags.
module uart_rx_core #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic         clk,
   input  logic         rst,
   uart_rx_core_if.slave bus
);
   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BRK
   } state_t;

   state_t               state;
   logic                 rxd_m;
   logic                 rxd_s;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 acc_pend;

   // Two-flop synchronizer for the asynchronous serial line, idles high
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= bus.rxd;
         rxd_s <= rxd_m;
      end
   end

   // Frame FSM: start qualification, data shifting, stop check and break hold-off
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         tick_cnt      <= '0;
         bit_cnt       <= '0;
         shift         <= '0;
         acc_pend      <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         acc_pend <= 1'b0;
         if (!bus.sel) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            bus.busy <= 1'b0;
         end else if (bus.baud_tick) begin
            case (state)
               S_IDLE: begin
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  if (!rxd_s) begin
                     state         <= S_START;
                     bus.frame_err <= 1'b0;
                     bus.busy      <= 1'b1;
                  end
               end
               S_START: begin
                  if (tick_cnt == TW'(OVERSAMPLE / 2 - 1)) begin
                     tick_cnt <= '0;
                     if (rxd_s) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                     end else begin
                        state <= S_DATA;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
               S_DATA: begin
                  if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
                     tick_cnt <= '0;
                     shift    <= DATA_BITS'({rxd_s, shift} >> 1);
                     if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        bit_cnt <= '0;
                        state   <= S_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
               S_STOP: begin
                  if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
                     tick_cnt <= '0;
                     if (rxd_s) begin
                        acc_pend <= 1'b1;
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                     end else begin
                        bus.frame_err <= 1'b1;
                        state         <= S_BRK;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
               S_BRK: begin
                  tick_cnt <= '0;
                  if (rxd_s) begin
                     state    <= S_IDLE;
                     bus.busy <= 1'b0;
                  end
               end
               default: begin
                  state    <= S_IDLE;
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  bus.busy <= 1'b0;
               end
            endcase
         end
      end
   end

   // Output holding register: load accepted bytes, flag overrun, clear on consumer ack
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.dout     <= '0;
         bus.dout_vld <= 1'b0;
         bus.overrun  <= 1'b0;
      end else begin
         if (bus.rd_ack) begin
            bus.dout_vld <= 1'b0;
            bus.overrun  <= 1'b0;
         end
         if (acc_pend) begin
            if (bus.dout_vld && !bus.rd_ack) begin
               bus.overrun <= 1'b1;
            end else begin
               bus.dout     <= shift;
               bus.dout_vld <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: scoreboard of expected bytes plus status checks.
module tb_uart_rx_core;
   localparam int unsigned DB = 8;
   localparam int unsigned OS = 16;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [DB-1:0] sb_q[$];
   logic [DB-1:0] sb_exp;
   logic          prev_vld;
   logic [DB-1:0] prev_dout;

   uart_rx_core_if #(.DATA_BITS(DB)) bus ();

   uart_rx_core #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Baud tick enable: one clk high every 4 clks
   initial begin
      bus.baud_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         bus.baud_tick = 1'b1;
         @(negedge clk);
         bus.baud_tick = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor: every newly loaded byte must match the oldest expected one
   initial begin
      prev_vld  = 1'b0;
      prev_dout = '0;
   end
   always @(negedge clk) begin
      if (bus.dout_vld === 1'b1 && (prev_vld !== 1'b1 || bus.dout !== prev_dout)) begin
         chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            sb_exp = sb_q.pop_front();
            chk("sb_dout", 32'(bus.dout), 32'(sb_exp));
         end
      end
      prev_vld  = bus.dout_vld;
      prev_dout = bus.dout;
   end

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (bus.baud_tick !== 1'b1) @(posedge clk);
      end
   endtask

   task automatic drive_rxd(input logic v);
      @(negedge clk);
      bus.rxd = v;
   endtask

   task automatic send_bits(input logic [DB-1:0] data, input int n);
      drive_rxd(1'b0);
      wait_ticks(OS);
      for (int i = 0; i < n; i++) begin
         drive_rxd(data[i]);
         wait_ticks(OS);
      end
   endtask

   task automatic send_frame(input logic [DB-1:0] data, input logic stop);
      send_bits(data, DB);
      drive_rxd(stop);
      wait_ticks(OS);
      drive_rxd(1'b1);
      wait_ticks(4);
   endtask

   task automatic ack_pulse();
      @(negedge clk);
      bus.rd_ack = 1'b1;
      @(negedge clk);
      bus.rd_ack = 1'b0;
   endtask

   // Called at a negedge; returns at the first negedge where busy is low
   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (bus.busy !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk({tag, "_timeout"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      bus.sel      = 1'b1;
      bus.rxd      = 1'b1;
      bus.rd_ack   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_dout", 32'(bus.dout), 32'h0);
      chk("rst_vld", 32'(bus.dout_vld), 32'd0);
      chk("rst_ferr", 32'(bus.frame_err), 32'd0);
      chk("rst_ovr", 32'(bus.overrun), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      wait_ticks(4);

      // 1: good frame, one clk latency after stop sample
      sb_q.push_back(8'hA5);
      send_bits(8'hA5, DB);
      drive_rxd(1'b1);
      wait_idle("t1");
      chk("t1_lat0_vld", 32'(bus.dout_vld), 32'd0);
      @(negedge clk);
      chk("t1_lat1_vld", 32'(bus.dout_vld), 32'd1);
      chk("t1_dout", 32'(bus.dout), 32'hA5);
      wait_ticks(OS);
      @(negedge clk);
      chk("t1_ferr", 32'(bus.frame_err), 32'd0);
      chk("t1_busy", 32'(bus.busy), 32'd0);
      ack_pulse();
      chk("t1_ack_vld", 32'(bus.dout_vld), 32'd0);

      // 2: short low glitch aborts in START
      drive_rxd(1'b0);
      wait_ticks(3);
      drive_rxd(1'b1);
      chk("t2_busy_mid", 32'(bus.busy), 32'd1);
      wait_ticks(12);
      @(negedge clk);
      chk("t2_busy", 32'(bus.busy), 32'd0);
      chk("t2_vld", 32'(bus.dout_vld), 32'd0);
      chk("t2_ferr", 32'(bus.frame_err), 32'd0);

      // 3: framing error into break, then recovery
      send_bits(8'h3C, DB);
      drive_rxd(1'b0);
      wait_ticks(40);
      @(negedge clk);
      chk("t3_ferr", 32'(bus.frame_err), 32'd1);
      chk("t3_vld", 32'(bus.dout_vld), 32'd0);
      chk("t3_busy_brk", 32'(bus.busy), 32'd1);
      drive_rxd(1'b1);
      wait_ticks(4);
      @(negedge clk);
      chk("t3_brk_exit", 32'(bus.busy), 32'd0);
      chk("t3_ferr_sticky", 32'(bus.frame_err), 32'd1);
      sb_q.push_back(8'h55);
      send_frame(8'h55, 1'b1);
      @(negedge clk);
      chk("t3_ferr_clr", 32'(bus.frame_err), 32'd0);
      chk("t3_dout", 32'(bus.dout), 32'h55);
      ack_pulse();

      // 4: overrun with no ack
      sb_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      @(negedge clk);
      chk("t4_dout", 32'(bus.dout), 32'h11);
      chk("t4_vld", 32'(bus.dout_vld), 32'd1);
      chk("t4_ovr", 32'(bus.overrun), 32'd1);
      ack_pulse();
      chk("t4_ack_vld", 32'(bus.dout_vld), 32'd0);
      chk("t4_ack_ovr", 32'(bus.overrun), 32'd0);

      // 5: ack coincident with accept edge
      sb_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      sb_q.push_back(8'h22);
      send_bits(8'h22, DB);
      drive_rxd(1'b1);
      wait_idle("t5");
      bus.rd_ack = 1'b1;
      @(negedge clk);
      bus.rd_ack = 1'b0;
      chk("t5_dout", 32'(bus.dout), 32'h22);
      chk("t5_vld", 32'(bus.dout_vld), 32'd1);
      chk("t5_ovr", 32'(bus.overrun), 32'd0);
      wait_ticks(OS);
      ack_pulse();

      // 6a: reset during bit 4
      send_bits(8'hF0, 4);
      drive_rxd(1'b1);
      wait_ticks(8);
      @(negedge clk);
      chk("t6_busy_pre", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_busy", 32'(bus.busy), 32'd0);
      chk("t6_rst_vld", 32'(bus.dout_vld), 32'd0);
      wait_ticks(20);
      @(negedge clk);
      chk("t6_idle", 32'(bus.busy), 32'd0);
      sb_q.push_back(8'hF0);
      send_frame(8'hF0, 1'b1);
      @(negedge clk);
      chk("t6_dout", 32'(bus.dout), 32'hF0);
      ack_pulse();

      // 6b: sel dropped during bit 4
      send_bits(8'h0F, 4);
      drive_rxd(1'b0);
      wait_ticks(8);
      @(negedge clk);
      bus.sel = 1'b0;
      bus.rxd = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_sel_busy", 32'(bus.busy), 32'd0);
      chk("t6_sel_vld", 32'(bus.dout_vld), 32'd0);
      bus.sel = 1'b1;
      wait_ticks(20);
      sb_q.push_back(8'h0F);
      send_frame(8'h0F, 1'b1);
      @(negedge clk);
      chk("t6_sel_dout", 32'(bus.dout), 32'h0F);
      chk("t6_sel_vld2", 32'(bus.dout_vld), 32'd1);
      ack_pulse();

      repeat (4) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
